// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, reads the word-addressed ROM and
// buffers {pc, word} pairs in an in-order queue drained over valid/ready.
module fetch_sequencer #(
    parameter int unsigned     QUEUE_DEPTH  = 4,
    parameter int unsigned     ROM_AW       = 8,
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter bit              STOP_ON_ZERO = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [ROM_AW-1:0]                rom_addr,
    input  logic [31:0]                      rom_data,
    input  logic                             redirect_valid,
    input  logic [PC_W-1:0]                  redirect_pc,
    output logic                             inst_valid,
    input  logic                             inst_ready,
    output logic [31:0]                      inst_data,
    output logic [PC_W-1:0]                  inst_pc,
    output logic                             fetch_done,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic [31:0]       data_q [QUEUE_DEPTH];
    logic [PC_W-1:0]   tag_q  [QUEUE_DEPTH];

    logic              enq;
    logic              deq;
    logic              space;
    logic [PC_W-1:0]   redirect_pc_aligned;
    logic              unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign inst_valid  = (count_q != '0);
    assign inst_data   = data_q[head_q];
    assign inst_pc     = tag_q[head_q];
    assign fetch_done  = done_q;
    assign queue_count = count_q;
    assign rom_addr    = pc_q[ROM_AW+1:2];

    // A redirect voids the consumer's handshake, so deq is never seen together with a flush.
    assign deq   = inst_valid & inst_ready & ~redirect_valid;
    assign space = (count_q < CNT_W'(QUEUE_DEPTH)) | deq;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        enq     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_aligned;
                end
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_aligned;
                end else if (STOP_ON_ZERO && (rom_data == 32'h0)) begin
                    state_d = S_DONE;
                end else if (space) begin
                    enq  = 1'b1;
                    pc_d = pc_q + PC_W'(4);
                end
            end
            S_DONE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc_aligned;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        done_d = (state_d == S_DONE) && (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (enq) begin
            data_q[tail_q] <= rom_data;
            tag_q[tail_q]  <= pc_q;
        end
    end

endmodule
